cdf_mem_ctrl: RTL
=================

# cdf_mem_ctrl

Upstream neighbour of the divider stage in the histogram-equalisation datapath. Streams the 64 histogram bins out of scratch memory, forms the running cumulative sum (CDF), and writes each CDF value into the scratch-memory CDF region that the divider stage later reads. On completion it reports the total pixel count and the first non-zero CDF value, and emits a one-cycle `cdf_done` pulse that serves as the divider stage's `enable`.

## Interface
Parameters:
- `BIN_BASE`, 16'd0: scratch address of histogram bin 0.
- `CDF_BASE`, 16'd64: scratch address of CDF entry 0.
- `NUM_BINS`, 64: bins per run, 2..127.
- `RD_LAT`, 2: scratch read latency in cycles, 1..4.
- `DW`, 16: bin and CDF data width.

Ports:
- `clk` input 1: single clock. All state changes on its rising edge.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: start request, sampled only in IDLE.
- `sc_mem_rd_addr` output 16: histogram read address.
- `sc_mem_rd_en` output 1: read issue strobe.
- `sc_mem_rd_data` input DW: read data, valid `RD_LAT` cycles after the address.
- `sc_mem_wt_addr` output 16: CDF write address.
- `sc_mem_wt_data` output DW: CDF write data.
- `sc_mem_wt_en` output 1: write strobe.
- `busy` output 1: high from RUN entry until the last write.
- `cdf_done` output 1: one-cycle completion pulse.
- `cdf_total` output DW: final (saturated) CDF value.
- `cdf_min` output DW: first non-zero CDF value; 0 if all bins are zero.

## Operation
- FSM states:
  - IDLE: enable goes to RUN; otherwise stay in IDLE.
  - RUN: issue one read per cycle, `NUM_BINS` reads in total. After the last issue, go to DRAIN.
  - DRAIN: wait until all `NUM_BINS` writes have been presented, then go to DONE.
  - DONE: `cdf_done`=1 for exactly one cycle, then go to IDLE.
- RUN entry clears the accumulator, the issue and return counters, the min-found flag, and the valid pipe.
- Read i (0..NUM_BINS-1): `sc_mem_rd_addr`=BIN_BASE+i, `sc_mem_rd_en`=1. Reads are consecutive, with no gaps.
- Valid pipe: an `RD_LAT`-deep shift register of rd_en marks returning data.
- On each returning datum: acc = min(acc + data, 2^DW-1). The sum is computed DW+1 bits wide and then clamped, so a saturated value never wraps.
- The next cycle presents the write: `sc_mem_wt_en`=1, `sc_mem_wt_addr`=CDF_BASE+j, `sc_mem_wt_data`=acc. Here j is the return index.
- `cdf_min` captures the first acc that is non-zero; later values never overwrite it.
- `cdf_total` is loaded with the final acc in the DONE cycle and held until the next DONE or reset.
- `enable` while not in IDLE is ignored. If `enable` is held high, a new run starts in the cycle after DONE+IDLE.
- Reset mid-run: FSM goes to IDLE, the pipe is flushed, all outputs go to 0, no pulse is emitted and no partial `cdf_total` is kept.
- Reset values: every output is 0, including the addresses.

## Timing
- Let `enable` be sampled high in IDLE at cycle T.
- Cycle T+1: RUN; first read presented at BIN_BASE; `busy`=1.
- Cycle T+NUM_BINS: last read presented.
- Cycle T+1+RD_LAT+1 (T+4 with defaults): first write, CDF_BASE ← bin0.
- Cycle T+NUM_BINS+RD_LAT+1 (T+67 with defaults): last write. `busy` falls after this cycle.
- Cycle T+NUM_BINS+RD_LAT+2 (T+68): `cdf_done`=1 and `cdf_total` is valid. `cdf_min` is valid from the same cycle.
- Throughput: one bin per cycle. Total latency from `enable` to done is NUM_BINS+RD_LAT+2 cycles.
- Write and read streams overlap. The bench's scratch model must support concurrent read and write; the address regions are disjoint.

## Structure
- Shared package `hist_eq_pkg` holds:
  - the scratch base addresses (0, 64, 128);
  - NUM_BINS, DW, RD_LAT defaults;
  - the FSM state constants for this block.
- The divider controller's region constants move into the same package.
- One sub-module: `sc_rd_valid_pipe`, the parameterised RD_LAT-deep valid/index shift register with synchronous clear. It is reusable by the divider read path.

## Test plan
- All bins = 1, enable at T:
  - writes 1..64 to addresses 64..127 at cycles T+4..T+67;
  - `cdf_done` at T+68; `cdf_total`=64, `cdf_min`=1.
- Bin 5 = 10, all other bins = 0:
  - addresses 64..68 get 0, addresses 69..127 get 10;
  - `cdf_min`=10, `cdf_total`=10.
- All bins = 16'h8000:
  - address 64 gets 16'h8000, addresses 65..127 get 16'hFFFF;
  - `cdf_total`=16'hFFFF, no wrap.
- All bins = 0: every write is 0; `cdf_total`=0, `cdf_min`=0; `cdf_done` still pulses at T+68.
- `enable` pulsed at T+10 and T+40: ignored, exactly one run. With `enable` held high, the second run's first read is at T+70.
- `reset` at T+30: next cycle all outputs are 0, `busy`=0, and no `cdf_done` follows. A fresh enable then gives a complete 64-write run with correct values.

Source files
------------

// File: rtl/hist_eq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hist_eq_pkg
// Purpose  : Shared constants for the histogram-equalisation datapath:
//            scratch-memory region bases, datapath defaults, and the state
//            encoding of the CDF memory controller.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hist_eq_pkg;

  // Scratch-memory regions: histogram bins, CDF table, divider output table.
  localparam logic [15:0] c_BIN_BASE = 16'd0;
  localparam logic [15:0] c_CDF_BASE = 16'd64;
  localparam logic [15:0] c_DIV_BASE = 16'd128;

  // Datapath defaults.
  localparam int c_NUM_BINS = 64;
  localparam int c_DW       = 16;
  localparam int c_RD_LAT   = 2;

  // Bin index width; covers NUM_BINS up to 127.
  localparam int c_IDX_W    = 7;

  // CDF controller states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sc_rd_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sc_rd_valid_pipe
// Purpose  : DEPTH-deep shift register that tracks scratch reads in flight.
//            Each issued read enters with its bin index; the pair emerges
//            DEPTH cycles later, aligned with the returning read data.
// Ports    : clk       - clock
//            reset     - synchronous active-high reset (flushes valids)
//            clr       - synchronous clear (flushes valids)
//            in_valid  - read issued this cycle
//            in_idx    - index of the issued read
//            out_valid - read data is returning this cycle
//            out_idx   - index of the returning read
// Revision : 1.0 - initial release
// ============================================================================
module sc_rd_valid_pipe #(
  parameter int DEPTH = 2,
  parameter int IW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [IW-1:0] in_idx,
  output logic          out_valid,
  output logic [IW-1:0] out_idx
);

  logic [DEPTH-1:0] r_vld;
  logic [IW-1:0]    r_idx [DEPTH];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
    end
  end

  // Index travels without reset; it is only meaningful alongside r_vld.
  always_ff @(posedge clk) begin
    r_idx[0] <= in_idx;
    for (int k = 1; k < DEPTH; k++) begin
      r_idx[k] <= r_idx[k-1];
    end
  end

  assign out_valid = r_vld[DEPTH-1];
  assign out_idx   = r_idx[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/cdf_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cdf_mem_ctrl
// Purpose  : Streams NUM_BINS histogram bins from scratch memory, forms the
//            saturating cumulative sum and writes it to the CDF region.
//            Reports the total and first non-zero CDF value, then pulses
//            cdf_done for one cycle to start the divider stage.
// Ports    : clk, reset       - clock, synchronous active-high reset
//            enable           - start request (sampled in IDLE only)
//            sc_mem_rd_*      - scratch read port (addr, en, data)
//            sc_mem_wt_*      - scratch write port (addr, data, en)
//            busy             - run in progress (first read .. last write)
//            cdf_done         - one-cycle completion pulse
//            cdf_total        - final saturated CDF value
//            cdf_min          - first non-zero CDF value (0 if none)
// Revision : 1.0 - initial release
// ============================================================================
module cdf_mem_ctrl
  import hist_eq_pkg::*;
#(
  parameter logic [15:0] BIN_BASE = c_BIN_BASE,
  parameter logic [15:0] CDF_BASE = c_CDF_BASE,
  parameter int          NUM_BINS = c_NUM_BINS,
  parameter int          RD_LAT   = c_RD_LAT,
  parameter int          DW       = c_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic [15:0]   sc_mem_rd_addr,
  output logic          sc_mem_rd_en,
  input  logic [DW-1:0] sc_mem_rd_data,
  output logic [15:0]   sc_mem_wt_addr,
  output logic [DW-1:0] sc_mem_wt_data,
  output logic          sc_mem_wt_en,
  output logic          busy,
  output logic          cdf_done,
  output logic [DW-1:0] cdf_total,
  output logic [DW-1:0] cdf_min
);

  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_BINS - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic [c_IDX_W-1:0] r_iss;
  logic               w_start;
  logic               w_ret_vld;
  logic [c_IDX_W-1:0] w_ret_idx;
  logic [DW:0]        w_sum;
  logic [DW-1:0]      w_acc_nx;
  logic [DW-1:0]      r_acc;
  logic               r_min_found;
  logic               r_last_wr;
  logic [15:0]        r_wt_addr;
  logic [DW-1:0]      r_wt_data;
  logic               r_wt_en;
  logic [DW-1:0]      r_total;
  logic [DW-1:0]      r_min;

  assign w_start = (r_state == ST_IDLE) && enable;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (enable) w_next = ST_RUN;
      ST_RUN:   if (r_iss == c_LAST_IDX) w_next = ST_DRAIN;
      // r_last_wr is high in the cycle the final write is on the port.
      ST_DRAIN: if (r_last_wr) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    sc_mem_rd_en   = 1'b0;
    sc_mem_rd_addr = '0;
    busy           = 1'b0;
    cdf_done       = 1'b0;
    case (r_state)
      ST_RUN: begin
        sc_mem_rd_en   = 1'b1;
        sc_mem_rd_addr = BIN_BASE + 16'(r_iss);
        busy           = 1'b1;
      end
      ST_DRAIN: busy     = 1'b1;
      ST_DONE:  cdf_done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- Read issue counter ----------------
  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_iss <= '0;
    end else if (sc_mem_rd_en) begin
      r_iss <= r_iss + 1'b1;
    end
  end

  sc_rd_valid_pipe #(
    .DEPTH (RD_LAT),
    .IW    (c_IDX_W)
  ) u_vpipe (
    .clk       (clk),
    .reset     (reset),
    .clr       (w_start),
    .in_valid  (sc_mem_rd_en),
    .in_idx    (r_iss),
    .out_valid (w_ret_vld),
    .out_idx   (w_ret_idx)
  );

  // One extra bit of headroom so an overflowing sum clamps instead of wrapping.
  assign w_sum    = {1'b0, r_acc} + {1'b0, sc_mem_rd_data};
  assign w_acc_nx = w_sum[DW] ? {DW{1'b1}} : w_sum[DW-1:0];

  // ---------------- Accumulate, write back, capture results ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_min_found <= 1'b0;
      r_min       <= '0;
      r_total     <= '0;
      r_last_wr   <= 1'b0;
      r_wt_en     <= 1'b0;
      r_wt_addr   <= '0;
      r_wt_data   <= '0;
    end else begin
      r_wt_en   <= 1'b0;
      r_last_wr <= 1'b0;
      if (w_start) begin
        r_acc       <= '0;
        r_min_found <= 1'b0;
        r_min       <= '0;
      end else if (w_ret_vld) begin
        r_acc     <= w_acc_nx;
        r_wt_en   <= 1'b1;
        r_wt_addr <= CDF_BASE + 16'(w_ret_idx);
        r_wt_data <= w_acc_nx;
        r_last_wr <= (w_ret_idx == c_LAST_IDX);
        if (!r_min_found && (w_acc_nx != '0)) begin
          r_min       <= w_acc_nx;
          r_min_found <= 1'b1;
        end
      end
      // Total becomes visible in the DONE cycle; accumulator is final by then.
      if ((r_state == ST_DRAIN) && r_last_wr) begin
        r_total <= r_acc;
      end
    end
  end

  assign sc_mem_wt_en   = r_wt_en;
  assign sc_mem_wt_addr = r_wt_addr;
  assign sc_mem_wt_data = r_wt_data;
  assign cdf_total      = r_total;
  assign cdf_min        = r_min;

endmodule
`default_nettype wire
